// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - region codes, master IDs and FSM states shared by the bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic [1:0] REG_RAM  = 2'b00;
    localparam logic [1:0] REG_MMIO = 2'b01;
    localparam logic [1:0] REG_ROM  = 2'b10;
    localparam logic [1:0] REG_NONE = 2'b11;

    localparam logic [1:0] M_DBG  = 2'd0;
    localparam logic [1:0] M_CPU  = 2'd1;
    localparam logic [1:0] M_DMA  = 2'd2;
    localparam logic [1:0] M_NONE = 2'd3;

    // The debug unit may always patch ROM; everyone else is refused when protection is on.
    function automatic logic access_blocked(input logic [1:0] master, input logic [1:0] region,
                                            input logic write, input logic rom_wp);
        return (region == REG_NONE) ||
               (rom_wp && (master != M_DBG) && (region == REG_ROM) && write);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_rr2.sv
// rtl/mem_bus_arbiter_arb_rr2.sv - two-request round-robin picker (pick 0 = m1, 1 = m2)
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick
);

    assign pick = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - three-master memory bus arbiter with region decode and ROM write protection
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_STATES = 0,
    parameter bit ROM_WP      = 1'b1
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        m0_valid,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,
    input  logic        m1_valid,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,
    input  logic        m2_valid,
    input  logic [31:0] m2_adr,
    input  logic [31:0] m2_wdata,
    input  logic [3:0]  m2_wstrb,
    output logic [31:0] m2_rdata,
    output logic        m2_ready,
    output logic        m2_err,
    output logic [31:0] s_adr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    output logic        ram_sel,
    output logic        mmio_sel,
    output logic        rom_sel,
    input  logic [31:0] s_rdata
);

    state_t      state;
    logic [1:0]  grant;
    logic [1:0]  region;
    logic        blocked;
    logic [3:0]  wait_cnt;
    logic        rr_last;
    logic        rr_pick;
    logic [1:0]  win;
    logic [1:0]  win_region;
    logic        win_write;
    logic [31:0] g_adr;
    logic [31:0] g_wdata;
    logic [3:0]  g_wstrb;
    logic [31:0] resp_data;
    logic        active;
    logic        resp;

    arb_rr2 u_rr (
        .req  ({m2_valid, m1_valid}),
        .last (rr_last),
        .pick (rr_pick)
    );

    always_comb begin
        win = M_NONE;
        if (m0_valid)
            win = M_DBG;
        else if (m1_valid || m2_valid)
            win = rr_pick ? M_DMA : M_CPU;
    end

    always_comb begin
        win_region = REG_RAM;
        win_write  = 1'b0;
        case (win)
            M_DBG: begin win_region = m0_adr[17:16]; win_write = |m0_wstrb; end
            M_CPU: begin win_region = m1_adr[17:16]; win_write = |m1_wstrb; end
            M_DMA: begin win_region = m2_adr[17:16]; win_write = |m2_wstrb; end
            default: ;
        endcase
    end

    // Address/data follow the granted master live; it holds them until ready.
    always_comb begin
        g_adr   = 32'h0;
        g_wdata = 32'h0;
        g_wstrb = 4'h0;
        case (grant)
            M_DBG: begin g_adr = m0_adr; g_wdata = m0_wdata; g_wstrb = m0_wstrb; end
            M_CPU: begin g_adr = m1_adr; g_wdata = m1_wdata; g_wstrb = m1_wstrb; end
            M_DMA: begin g_adr = m2_adr; g_wdata = m2_wdata; g_wstrb = m2_wstrb; end
            default: ;
        endcase
    end

    // rr_last = 1 means m2 was the most recent m1/m2 grant.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= ST_IDLE;
            grant    <= M_NONE;
            region   <= REG_RAM;
            blocked  <= 1'b0;
            wait_cnt <= 4'h0;
            rr_last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win != M_NONE) begin
                        state    <= ST_ACCESS;
                        grant    <= win;
                        region   <= win_region;
                        blocked  <= access_blocked(win, win_region, win_write, ROM_WP);
                        wait_cnt <= 4'(WAIT_STATES);
                        if (win != M_DBG)
                            rr_last <= (win == M_DMA);
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == 4'h0)
                        state <= ST_RESP;
                    else
                        wait_cnt <= wait_cnt - 4'd1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    grant <= M_NONE;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= M_NONE;
                end
            endcase
        end
    end

    assign active    = (state == ST_ACCESS) || (state == ST_RESP);
    assign resp      = (state == ST_RESP);
    assign resp_data = blocked ? 32'h0 : s_rdata;

    assign s_adr    = active ? g_adr : 32'h0;
    assign s_wdata  = active ? g_wdata : 32'h0;
    // Strobes only in ACCESS so an MMIO FIFO never sees the same write twice.
    assign s_wstrb  = ((state == ST_ACCESS) && !blocked) ? g_wstrb : 4'h0;
    assign ram_sel  = active && (region == REG_RAM);
    assign mmio_sel = active && (region == REG_MMIO);
    assign rom_sel  = active && (region == REG_ROM);

    assign m0_ready = resp && (grant == M_DBG);
    assign m1_ready = resp && (grant == M_CPU);
    assign m2_ready = resp && (grant == M_DMA);
    assign m0_err   = m0_ready && blocked;
    assign m1_err   = m1_ready && blocked;
    assign m2_err   = m2_ready && blocked;
    assign m0_rdata = m0_ready ? resp_data : 32'h0;
    assign m1_rdata = m1_ready ? resp_data : 32'h0;
    assign m2_rdata = m2_ready ? resp_data : 32'h0;

endmodule
